// File: rtl/rp_shutdown_ctrl.sv
// Static-side shutdown / drain / decouple / reset sequencer for one reconfigurable partition.
// Optional build macro RP_SHUTDOWN_STATS_EN adds the REQ-phase ack_latency measurement.
module rp_shutdown_ctrl #(
  parameter int TIMEOUT_CYCLES = 65536,
  parameter int RST_CYCLES     = 16,
  parameter int DMA_WIDTH      = 128
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_shutdown,
  input  logic                 req_start,
  output logic                 shutdown_req,
  input  logic                 shutdown_ack,
  input  logic                 rp_active,
  output logic                 decouple,
  output logic                 rp_rst_n,
  output logic                 done,
  output logic                 timed_out,
  output logic [2:0]           state,
  output logic [31:0]          ack_latency,
  input  logic [DMA_WIDTH-1:0] s_axis_dma_tdata,
  input  logic                 s_axis_dma_tlast,
  input  logic                 s_axis_dma_tvalid,
  output logic                 s_axis_dma_tready,
  output logic [DMA_WIDTH-1:0] m_axis_dma_tdata,
  output logic                 m_axis_dma_tlast,
  output logic                 m_axis_dma_tvalid,
  input  logic                 m_axis_dma_tready
);

  typedef enum logic [2:0] {
    ST_RUN       = 3'd0,
    ST_REQ       = 3'd1,
    ST_DRAIN     = 3'd2,
    ST_DECOUPLED = 3'd3,
    ST_RESET     = 3'd4,
    ST_RELEASE   = 3'd5
  } state_t;

  typedef struct packed {
    logic sreq;
    logic dec;
    logic rstn;
    logic dn;
  } ctl_t;

  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam int RW = $clog2(RST_CYCLES) + 1;
  localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [RW-1:0] RST_LAST = RW'(RST_CYCLES - 1);

  state_t        st;
  ctl_t          ctl;
  logic [CW-1:0] cnt;
  logic [RW-1:0] rcnt;
  logic          in_packet;
  logic          term;
  logic          pass;
  logic          hs;

  // Control outputs are a pure function of the state being entered, so they
  // are loaded together with the state register and never glitch.
  function automatic ctl_t ctl_for(state_t s);
    ctl_t c;
    c = '{sreq: 1'b0, dec: 1'b1, rstn: 1'b0, dn: 1'b0};
    case (s)
      ST_RUN:           c = '{sreq: 1'b0, dec: 1'b0, rstn: 1'b1, dn: 1'b0};
      ST_REQ, ST_DRAIN: c = '{sreq: 1'b1, dec: 1'b0, rstn: 1'b1, dn: 1'b0};
      ST_DECOUPLED:     c = '{sreq: 1'b1, dec: 1'b1, rstn: 1'b1, dn: 1'b1};
      ST_RELEASE:       c = '{sreq: 1'b0, dec: 1'b1, rstn: 1'b1, dn: 1'b0};
      default:          c = '{sreq: 1'b0, dec: 1'b1, rstn: 1'b0, dn: 1'b0};
    endcase
    return c;
  endfunction

  assign state        = st;
  assign shutdown_req = ctl.sreq;
  assign decouple     = ctl.dec;
  assign rp_rst_n     = ctl.rstn;
  assign done         = ctl.dn;

  // NOTE: every output is assigned on every path, so no latch can be inferred.
  always_comb begin
    pass = (st == ST_RUN) || (st == ST_REQ) || (st == ST_DRAIN && in_packet && !term);
    m_axis_dma_tvalid = pass ? s_axis_dma_tvalid : term;
    m_axis_dma_tdata  = pass ? s_axis_dma_tdata  : '0;
    m_axis_dma_tlast  = pass ? s_axis_dma_tlast  : term;
    s_axis_dma_tready = pass & m_axis_dma_tready;
    hs = m_axis_dma_tvalid & m_axis_dma_tready;
  end

  // NOTE: non-blocking assignments only, so every branch reads pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st        <= ST_RESET;
      ctl       <= ctl_for(ST_RESET);
      cnt       <= '0;
      rcnt      <= '0;
      term      <= 1'b0;
      timed_out <= 1'b0;
      in_packet <= 1'b0;
    end else begin
      if (st == ST_RESET) in_packet <= 1'b0;
      else if (hs)        in_packet <= !m_axis_dma_tlast;

      case (st)
        ST_RUN: if (req_shutdown) begin
          st        <= ST_REQ;
          ctl       <= ctl_for(ST_REQ);
          cnt       <= '0;
          timed_out <= 1'b0;
        end
        ST_REQ: begin
          // A late ack landing on the last allowed cycle still counts as an ack.
          if (shutdown_ack || cnt == TO_LAST) begin
            st  <= ST_DRAIN;
            ctl <= ctl_for(ST_DRAIN);
            cnt <= '0;
            if (!shutdown_ack) timed_out <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DRAIN: begin
          if (term) begin
            if (m_axis_dma_tready) begin
              term <= 1'b0;
              st   <= ST_DECOUPLED;
              ctl  <= ctl_for(ST_DECOUPLED);
            end
          end else if (!in_packet || (hs && m_axis_dma_tlast)) begin
            st  <= ST_DECOUPLED;
            ctl <= ctl_for(ST_DECOUPLED);
          end else if (cnt == TO_LAST) begin
            // RP stalled mid-packet: close the packet ourselves so the DMA sees a boundary.
            term      <= 1'b1;
            timed_out <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DECOUPLED: if (req_start) begin
          st   <= ST_RESET;
          ctl  <= ctl_for(ST_RESET);
          rcnt <= '0;
        end
        ST_RESET: begin
          if (rcnt == RST_LAST) begin
            st  <= ST_RELEASE;
            ctl <= ctl_for(ST_RELEASE);
          end else begin
            rcnt <= rcnt + 1'b1;
          end
        end
        ST_RELEASE: if (rp_active) begin
          st  <= ST_RUN;
          ctl <= ctl_for(ST_RUN);
        end
        default: begin
          st   <= ST_RESET;
          ctl  <= ctl_for(ST_RESET);
          rcnt <= '0;
        end
      endcase
    end
  end

`ifdef RP_SHUTDOWN_STATS_EN
  logic [31:0] lat_cnt;
  logic        req_exit;

  assign req_exit = (st == ST_REQ) && (shutdown_ack || cnt == TO_LAST);

  // lat_cnt counts REQ cycles including the current one; saturates at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_cnt     <= '0;
      ack_latency <= '0;
    end else if (st == ST_RUN && req_shutdown) begin
      lat_cnt <= 32'd1;
    end else if (st == ST_REQ) begin
      if (req_exit)              ack_latency <= lat_cnt;
      else if (lat_cnt != '1)    lat_cnt     <= lat_cnt + 1'b1;
    end
  end
`else
  assign ack_latency = '0;
`endif

endmodule
